matmul_relu_sequencer: RTL and testbench

Sequential controller that computes a 2x2 signed matrix product C = A x B on one shared multiply-accumulate unit. It optionally applies ReLU to every result element. It accepts a full operand set through a valid/ready handshake, runs 8 MAC steps, and presents C through a second valid/ready handshake. It is the area-reduced, time-multiplexed counterpart of the combinational matrix_multiplication + relu datapath, and is intended for placement between an operand source and a downstream consumer.

---
 rtl/matmul_relu_sequencer_if.sv | 37 +++
 rtl/matmul_relu_sequencer.sv | 121 ++++++++++++
 tb/tb_matmul_relu_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/matmul_relu_sequencer_if.sv
// Operand/result bundle for the time-multiplexed 2x2 matrix multiply sequencer.
// The master side supplies operands and consumes results; the slave side is the sequencer.
interface matmul_relu_sequencer_if #(
    parameter int DATA_W = 64
);
    localparam int ACC_W = 2 * DATA_W;

    logic              in_valid;
    logic              in_ready;
    logic              relu_en;
    logic [DATA_W-1:0] a00;
    logic [DATA_W-1:0] a01;
    logic [DATA_W-1:0] a10;
    logic [DATA_W-1:0] a11;
    logic [DATA_W-1:0] b00;
    logic [DATA_W-1:0] b01;
    logic [DATA_W-1:0] b10;
    logic [DATA_W-1:0] b11;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  c00;
    logic [ACC_W-1:0]  c01;
    logic [ACC_W-1:0]  c10;
    logic [ACC_W-1:0]  c11;
    logic              busy;
    logic [2:0]        step;

    modport master (
        output in_valid, relu_en, a00, a01, a10, a11, b00, b01, b10, b11, out_ready,
        input  in_ready, out_valid, c00, c01, c10, c11, busy, step
    );

    modport slave (
        input  in_valid, relu_en, a00, a01, a10, a11, b00, b01, b10, b11, out_ready,
        output in_ready, out_valid, c00, c01, c10, c11, busy, step
    );
endinterface

// File: rtl/matmul_relu_sequencer.sv
// Computes C = A x B (2x2, signed) on a single shared MAC over 8 steps, with optional ReLU,
// using valid/ready handshakes on both the operand and the result side.
module matmul_relu_sequencer #(
    parameter int DATA_W = 64
) (
    input logic                     clk,
    input logic                     rst,
    matmul_relu_sequencer_if.slave  bus
);
    localparam int ACC_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [DATA_W-1:0] a_reg [4];
    logic [DATA_W-1:0] b_reg [4];
    logic              relu_reg;
    logic [ACC_W-1:0]  acc   [4];
    logic [ACC_W-1:0]  c_reg [4];
    logic [2:0]        step_reg;
    logic              drain;

    logic [1:0]        elem;
    logic              term;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [ACC_W-1:0]  prod;

    // Step k works on element k[2:1] (row = bit 1, column = bit 0) using inner term k[0]
    always_comb begin
        elem  = step_reg[2:1];
        term  = step_reg[0];
        mul_a = a_reg[{elem[1], term}];
        mul_b = b_reg[{term, elem[0]}];
        prod  = {{DATA_W{mul_a[DATA_W-1]}}, mul_a} * {{DATA_W{mul_b[DATA_W-1]}}, mul_b};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = MAC;
            MAC:     if (drain)         state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state == MAC) || (state == DONE);
        bus.step      = (state == MAC) ? step_reg : 3'd0;
        bus.c00       = c_reg[0];
        bus.c01       = c_reg[1];
        bus.c10       = c_reg[2];
        bus.c11       = c_reg[3];
    end

    // Operands are only captured on accept, so later input changes cannot disturb a job
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            a_reg[0] <= bus.a00;
            a_reg[1] <= bus.a01;
            a_reg[2] <= bus.a10;
            a_reg[3] <= bus.a11;
            b_reg[0] <= bus.b00;
            b_reg[1] <= bus.b01;
            b_reg[2] <= bus.b10;
            b_reg[3] <= bus.b11;
            relu_reg <= bus.relu_en;
        end
    end

    // After the eighth product the drain cycle loads the results, giving the extra DONE-load edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            step_reg <= 3'd0;
            drain    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc[i]   <= '0;
                c_reg[i] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        step_reg <= 3'd0;
                        drain    <= 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            acc[i] <= '0;
                        end
                    end
                end
                MAC: begin
                    if (!drain) begin
                        acc[elem] <= acc[elem] + prod;
                        step_reg  <= step_reg + 3'd1;
                        if (step_reg == 3'd7) begin
                            drain <= 1'b1;
                        end
                    end else begin
                        drain <= 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            c_reg[i] <= (relu_reg && acc[i][ACC_W-1]) ? '0 : acc[i];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_relu_sequencer.sv
// Directed self-checking bench for matmul_relu_sequencer: hand-computed products,
// ReLU, wraparound, backpressure, mid-job reset and back-to-back issue.
module tb_matmul_relu_sequencer;
    localparam int DATA_W = 64;
    localparam int ACC_W  = 2 * DATA_W;

    localparam logic [ACC_W-1:0] ONE   = 1;
    localparam logic [ACC_W-1:0] ZERO  = 0;
    localparam logic [ACC_W-1:0] NEG5  = -128'sd5;
    localparam logic [ACC_W-1:0] NEG6  = -128'sd6;
    localparam logic [ACC_W-1:0] TOPB  = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [DATA_W-1:0] MINV = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    matmul_relu_sequencer_if #(.DATA_W(DATA_W)) bus ();

    matmul_relu_sequencer #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [ACC_W-1:0] b2w(input logic b);
        return {{(ACC_W-1){1'b0}}, b};
    endfunction

    task automatic checkOutput(input string tag, input logic [ACC_W-1:0] got,
                               input logic [ACC_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveOperands(input logic [DATA_W-1:0] x00, x01, x10, x11,
                                 input logic [DATA_W-1:0] y00, y01, y10, y11,
                                 input logic relu);
        bus.a00 = x00; bus.a01 = x01; bus.a10 = x10; bus.a11 = x11;
        bus.b00 = y00; bus.b01 = y01; bus.b10 = y10; bus.b11 = y11;
        bus.relu_en = relu;
    endtask

    // Raises in_valid, waits for in_ready and lets one accept edge pass
    task automatic applyStimulus(input string tag, input logic hold);
        int n = 0;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_in_ready"}, b2w(bus.in_ready), ONE);
        tick();
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic waitResult(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.out_valid && n < 20);
        checkOutput({tag, "_latency"}, ACC_W'(n), ACC_W'(9));
    endtask

    task automatic checkC(input string tag, input logic [ACC_W-1:0] e00, e01, e10, e11);
        checkOutput({tag, "_c00"}, bus.c00, e00);
        checkOutput({tag, "_c01"}, bus.c01, e01);
        checkOutput({tag, "_c10"}, bus.c10, e10);
        checkOutput({tag, "_c11"}, bus.c11, e11);
    endtask

    task automatic runJob(input string tag,
                          input logic [DATA_W-1:0] x00, x01, x10, x11,
                          input logic [DATA_W-1:0] y00, y01, y10, y11,
                          input logic relu,
                          input logic [ACC_W-1:0] e00, e01, e10, e11);
        driveOperands(x00, x01, x10, x11, y00, y01, y10, y11, relu);
        bus.out_ready = 1'b1;
        applyStimulus(tag, 1'b0);
        checkOutput({tag, "_busy"}, b2w(bus.busy), ONE);
        waitResult(tag);
        checkC(tag, e00, e01, e10, e11);
        tick();
        checkOutput({tag, "_released"}, b2w(bus.out_valid), ZERO);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        logic seen;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        driveOperands('0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        checkOutput("rst_in_ready",  b2w(bus.in_ready),  ONE);
        checkOutput("rst_out_valid", b2w(bus.out_valid), ZERO);
        checkOutput("rst_busy",      b2w(bus.busy),      ZERO);
        checkOutput("rst_step",      ACC_W'(bus.step),   ZERO);
        checkC("rst", ZERO, ZERO, ZERO, ZERO);

        runJob("basic", 1, 2, 3, 4, 5, 6, 7, 8, 1'b0, 19, 22, 43, 50);
        runJob("signed", -1, 0, 0, 1, 5, 6, 7, 8, 1'b0, NEG5, NEG6, 7, 8);
        runJob("signed_relu", -1, 0, 0, 1, 5, 6, 7, 8, 1'b1, ZERO, ZERO, 7, 8);
        runJob("wrap", MINV, MINV, 0, 0, MINV, 0, MINV, 0, 1'b0, TOPB, ZERO, ZERO, ZERO);
        runJob("wrap_relu", MINV, MINV, 0, 0, MINV, 0, MINV, 0, 1'b1, ZERO, ZERO, ZERO, ZERO);

        // Backpressure: results must hold while the consumer stalls
        driveOperands(1, 2, 3, 4, 5, 6, 7, 8, 1'b0);
        bus.out_ready = 1'b0;
        applyStimulus("bp", 1'b0);
        waitResult("bp");
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_out_valid", b2w(bus.out_valid), ONE);
            checkOutput("bp_in_ready",  b2w(bus.in_ready),  ZERO);
            checkOutput("bp_c00",       bus.c00,            ACC_W'(19));
            checkOutput("bp_c11",       bus.c11,            ACC_W'(50));
        end
        bus.out_ready = 1'b1;
        tick();
        checkOutput("bp_release_valid", b2w(bus.out_valid), ZERO);
        checkOutput("bp_release_ready", b2w(bus.in_ready),  ONE);

        // Reset in the middle of a job discards it
        driveOperands(-1, 0, 0, 1, 5, 6, 7, 8, 1'b0);
        applyStimulus("abort", 1'b0);
        n = 0;
        while (bus.step != 3'd3 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("abort_step3", ACC_W'(bus.step), ACC_W'(3));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_in_ready",  b2w(bus.in_ready),  ONE);
        checkOutput("abort_busy",      b2w(bus.busy),      ZERO);
        checkOutput("abort_out_valid", b2w(bus.out_valid), ZERO);
        checkOutput("abort_step",      ACC_W'(bus.step),   ZERO);
        checkC("abort", ZERO, ZERO, ZERO, ZERO);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        checkOutput("abort_no_valid", b2w(seen), ZERO);
        runJob("after_abort", 1, 2, 3, 4, 5, 6, 7, 8, 1'b0, 19, 22, 43, 50);

        // Back-to-back with in_valid held high; operands change during the first job
        driveOperands(1, 2, 3, 4, 5, 6, 7, 8, 1'b0);
        bus.out_ready = 1'b1;
        applyStimulus("b2b_first", 1'b1);
        driveOperands(-1, 0, 0, 1, 5, 6, 7, 8, 1'b0);
        waitResult("b2b_first");
        checkC("b2b_first", 19, 22, 43, 50);
        tick();
        checkOutput("b2b_handshake_valid", b2w(bus.out_valid), ZERO);
        checkOutput("b2b_handshake_ready", b2w(bus.in_ready),  ONE);
        tick();
        checkOutput("b2b_second_busy",  b2w(bus.busy),     ONE);
        checkOutput("b2b_second_ready", b2w(bus.in_ready), ZERO);
        bus.in_valid = 1'b0;
        driveOperands('0, '0, '0, '0, '0, '0, '0, '0, 1'b1);
        waitResult("b2b_second");
        checkC("b2b_second", NEG5, NEG6, 7, 8);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
